// File: rtl/reg_file_mp_pkg.sv
// Shared types and default sizes for the multi-port register file.
package reg_file_mp_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one busy bit per register, set by reservations,
// cleared by load writeback, with combinational lookup for both read ports.
module reg_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic              o_busy1_c,
  output logic              o_busy2_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Set is applied after clear so a new reservation wins over a completing load.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_en && i_clr) begin
      w_busy_nxt[i_clr_addr] = 1'b0;
    end
    if (i_en && i_set) begin
      w_busy_nxt[i_set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // A load completing this cycle is no longer reported as pending.
  assign o_busy1_c = i_en && r_busy[i_rd_addr1] && !(i_clr && (i_clr_addr == i_rd_addr1));
  assign o_busy2_c = i_en && r_busy[i_rd_addr2] && !(i_clr && (i_clr_addr == i_rd_addr2));

endmodule

// File: rtl/reg_file_mp.sv
// Two-read / two-write register file with write-through bypass, a pending-load
// scoreboard, and a post-reset sweep that clears the array one entry per cycle.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [CNT_W-1:0]  r_init_cnt;
  logic              r_ready;
  logic [DATA_W-1:0] r_regs [DEPTH];

  logic              w_run;
  logic              w_sweep_done;

  assign w_run        = (r_state == RUN);
  assign w_sweep_done = (r_init_cnt == CNT_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (w_sweep_done) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = INIT;
    endcase
  end

  // Sweep counter holds at DEPTH-1 once RUN is reached; ready tracks next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == RUN);
      if ((r_state == INIT) && !w_sweep_done) begin
        r_init_cnt <= r_init_cnt + CNT_W'(1);
      end
    end
  end

  // Array has no reset; port A is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_regs[r_init_cnt[ADDR_W-1:0]] <= '0;
    end else begin
      if (wr_en_b) begin
        r_regs[wr_addr_b] <= wr_data_b;
      end
      if (wr_en_a) begin
        r_regs[wr_addr_a] <= wr_data_a;
      end
    end
  end

  always_comb begin
    rd_data1 = '0;
    if (w_run) begin
      if (wr_en_a && (wr_addr_a == rd_addr1)) begin
        rd_data1 = wr_data_a;
      end else if (wr_en_b && (wr_addr_b == rd_addr1)) begin
        rd_data1 = wr_data_b;
      end else begin
        rd_data1 = r_regs[rd_addr1];
      end
    end
  end

  always_comb begin
    rd_data2 = '0;
    if (w_run) begin
      if (wr_en_a && (wr_addr_a == rd_addr2)) begin
        rd_data2 = wr_data_a;
      end else if (wr_en_b && (wr_addr_b == rd_addr2)) begin
        rd_data2 = wr_data_b;
      end else begin
        rd_data2 = r_regs[rd_addr2];
      end
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst),
    .i_en       (w_run),
    .i_set      (rsv_en),
    .i_set_addr (rsv_addr),
    .i_clr      (wr_en_b),
    .i_clr_addr (wr_addr_b),
    .i_rd_addr1 (rd_addr1),
    .i_rd_addr2 (rd_addr2),
    .o_busy1_c  (rd_busy1),
    .o_busy2_c  (rd_busy2)
  );

  assign ready = r_ready;

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed bench for reg_file_mp against an array-based reference model.
module tb_reg_file_mp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_busy1, rd_busy2;
  logic          wr_en_a, wr_en_b, rsv_en;
  logic [AW-1:0] wr_addr_a, wr_addr_b, rsv_addr;
  logic [DW-1:0] wr_data_a, wr_data_b;
  logic          ready;

  logic [DW-1:0] m_regs [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_run;
  int            m_left;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2),
    .rd_busy1  (rd_busy1),
    .rd_busy2  (rd_busy2),
    .wr_en_a   (wr_en_a),
    .wr_addr_a (wr_addr_a),
    .wr_data_a (wr_data_a),
    .wr_en_b   (wr_en_b),
    .wr_addr_b (wr_addr_b),
    .wr_data_b (wr_data_b),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (!m_run) return '0;
    if (wr_en_a && wr_addr_a == a) return wr_data_a;
    if (wr_en_b && wr_addr_b == a) return wr_data_b;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return m_run && m_busy[a] && !(wr_en_b && wr_addr_b == a);
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_left = DEPTH;
    for (int k = 0; k < DEPTH; k++) m_busy[k] = 1'b0;
  endtask

  // Reference behaviour at a rising edge; a completed sweep leaves every register zero.
  task automatic model_edge();
    if (!m_run) begin
      m_left--;
      if (m_left == 0) begin
        m_run = 1'b1;
        for (int k = 0; k < DEPTH; k++) m_regs[k] = '0;
      end
    end else begin
      if (wr_en_b) begin
        m_regs[wr_addr_b] = wr_data_b;
        m_busy[wr_addr_b] = 1'b0;
      end
      if (wr_en_a) m_regs[wr_addr_a] = wr_data_a;
      if (rsv_en)  m_busy[rsv_addr]  = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".ready"}, DW'(ready),    DW'(m_run));
    chk({tag, ".rd1"},   rd_data1,      exp_rd(rd_addr1));
    chk({tag, ".rd2"},   rd_data2,      exp_rd(rd_addr2));
    chk({tag, ".busy1"}, DW'(rd_busy1), DW'(exp_busy(rd_addr1)));
    chk({tag, ".busy2"}, DW'(rd_busy2), DW'(exp_busy(rd_addr2)));
  endtask

  task automatic sample(input string tag);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input string tag);
    sample(tag);
    edge_step();
  endtask

  task automatic set_idle();
    wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
    wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    rsv_en  = 1'b0; rsv_addr  = '0;
    rd_addr1 = '0;  rd_addr2  = '0;
  endtask

  task automatic rand_inputs();
    rd_addr1  = AW'($urandom_range(0, DEPTH - 1));
    rd_addr2  = AW'($urandom_range(0, DEPTH - 1));
    wr_en_a   = ($urandom_range(0, 1) == 1);
    wr_addr_a = AW'($urandom_range(0, DEPTH - 1));
    wr_data_a = $urandom;
    wr_en_b   = ($urandom_range(0, 2) == 0);
    wr_addr_b = AW'($urandom_range(0, DEPTH - 1));
    wr_data_b = $urandom;
    rsv_en    = ($urandom_range(0, 1) == 1);
    rsv_addr  = AW'($urandom_range(0, DEPTH - 1));
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    model_reset();
    for (int k = 0; k < DEPTH; k++) m_regs[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    sample("in_reset");
    edge_step();
    model_reset();
    rst = 1'b1;

    // Initial sweep with random traffic that must be ignored.
    for (int i = 0; i < DEPTH; i++) begin
      rand_inputs();
      sample("init");
      chk("init_ready_low", DW'(ready), DW'(0));
      edge_step();
    end
    set_idle();
    sample("sweep_done");
    chk("ready_after_16", DW'(ready), DW'(1));
    edge_step();
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr1 = AW'(i);
      rd_addr2 = AW'(DEPTH - 1 - i);
      sample("zero_read");
      chk("zero_read.rd1", rd_data1, '0);
      edge_step();
    end

    // Port A bypass, then stored value.
    set_idle();
    wr_en_a = 1'b1; wr_addr_a = 4'd3; wr_data_a = 32'hDEADBEEF; rd_addr1 = 4'd3;
    sample("bypass_a");
    chk("bypass_a.lit", rd_data1, 32'hDEADBEEF);
    edge_step();
    set_idle(); rd_addr1 = 4'd3;
    sample("stored_a");
    chk("stored_a.lit", rd_data1, 32'hDEADBEEF);
    edge_step();

    // Same-address double write: port A wins.
    set_idle();
    wr_en_a = 1'b1; wr_addr_a = 4'd5; wr_data_a = 32'h11;
    wr_en_b = 1'b1; wr_addr_b = 4'd5; wr_data_b = 32'h22; rd_addr1 = 4'd5;
    sample("collide");
    chk("collide_bypass.lit", rd_data1, 32'h11);
    edge_step();
    set_idle(); rd_addr1 = 4'd5;
    sample("collide_stored");
    chk("collide_stored.lit", rd_data1, 32'h11);
    edge_step();

    // Reserve 7, port A leaves it busy, port B clears it.
    set_idle(); rsv_en = 1'b1; rsv_addr = 4'd7; rd_addr1 = 4'd7;
    step("rsv7");
    set_idle(); rd_addr1 = 4'd7;
    wr_en_a = 1'b1; wr_addr_a = 4'd7; wr_data_a = 32'h99;
    sample("rsv7_a");
    chk("rsv7_busy.lit", DW'(rd_busy1), DW'(1));
    edge_step();
    set_idle(); rd_addr1 = 4'd7;
    sample("rsv7_after_a");
    chk("rsv7_after_a.lit", DW'(rd_busy1), DW'(1));
    edge_step();
    wr_en_b = 1'b1; wr_addr_b = 4'd7; wr_data_b = 32'h55;
    sample("rsv7_b");
    chk("rsv7_b_busy.lit", DW'(rd_busy1), DW'(0));
    edge_step();
    set_idle(); rd_addr1 = 4'd7;
    sample("rsv7_done");
    chk("rsv7_data.lit", rd_data1, 32'h55);
    chk("rsv7_clear.lit", DW'(rd_busy1), DW'(0));
    edge_step();

    // Reserve and writeback on the same address: reservation wins; re-reserve is benign.
    set_idle(); rsv_en = 1'b1; rsv_addr = 4'd9;
    wr_en_b = 1'b1; wr_addr_b = 4'd9; wr_data_b = 32'h77; rd_addr1 = 4'd9;
    step("rsv9_b");
    set_idle(); rsv_en = 1'b1; rsv_addr = 4'd9; rd_addr1 = 4'd9;
    sample("rsv9_again");
    chk("rsv9_busy.lit", DW'(rd_busy1), DW'(1));
    edge_step();
    set_idle(); rd_addr1 = 4'd9;
    sample("rsv9_still");
    chk("rsv9_still.lit", DW'(rd_busy1), DW'(1));
    edge_step();

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step("rand");
    end

    // Asynchronous reset mid-RUN with a pending reservation.
    set_idle(); rsv_en = 1'b1; rsv_addr = 4'd2;
    wr_en_a = 1'b1; wr_addr_a = 4'd3; wr_data_a = 32'hABCD;
    step("pre_rst");
    set_idle(); rd_addr1 = 4'd2; rd_addr2 = 4'd3;
    sample("pre_rst_chk");
    chk("pre_rst_busy2.lit", DW'(rd_busy1), DW'(1));
    chk("pre_rst_reg3.lit", rd_data2, 32'hABCD);
    edge_step();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_ready.lit", DW'(ready), DW'(0));
    chk("rst_busy.lit", DW'(rd_busy1), DW'(0));
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rand_inputs();
      step("resweep");
    end
    set_idle(); rd_addr1 = 4'd2; rd_addr2 = 4'd3;
    sample("post_rst");
    chk("post_rst_reg3.lit", rd_data2, '0);
    chk("post_rst_ready.lit", DW'(ready), DW'(1));
    edge_step();

    for (int i = 0; i < 100; i++) begin
      rand_inputs();
      step("rand2");
    end

    // Reset in the middle of the sweep restarts it from the beginning.
    rst = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_inputs();
      step("init_a");
    end
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_in_init");
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rand_inputs();
      step("init_b");
    end
    for (int i = 0; i < 50; i++) begin
      rand_inputs();
      step("rand3");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
